// File: rtl/timer_share_pkg.sv
// Shared types and constants for the interval-timer share scheduler.
// Holds the FSM state enum, timer register map and control words.
package timer_share_pkg;

    localparam int TMR_AW = 3;
    localparam int TMR_DW = 16;

    localparam logic [TMR_AW-1:0] TMR_ADDR_STATUS   = 3'd0;
    localparam logic [TMR_AW-1:0] TMR_ADDR_CONTROL  = 3'd1;
    localparam logic [TMR_AW-1:0] TMR_ADDR_PERIOD_L = 3'd2;
    localparam logic [TMR_AW-1:0] TMR_ADDR_PERIOD_H = 3'd3;

    localparam int CTRL_ITO_BIT   = 0;
    localparam int CTRL_CONT_BIT  = 1;
    localparam int CTRL_START_BIT = 2;
    localparam int CTRL_STOP_BIT  = 3;

    localparam logic [TMR_DW-1:0] CTRL_STOP_WORD  = 16'h0008;
    localparam logic [TMR_DW-1:0] CTRL_START_WORD = 16'h0005;
    localparam logic [TMR_DW-1:0] STATUS_CLR_WORD = 16'h0000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_STOP,
        ST_WR_CLR,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_START,
        ST_WAIT_IRQ,
        ST_WR_ACK,
        ST_WR_ABORT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin pick: first set request at or above ptr_i, wrapping.
// Ports: req_i, ptr_i in; gnt_valid_o, gnt_oh_o (one-hot), gnt_idx_o out.
module rr_arbiter_onehot #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             gnt_valid_o,
    output logic [N-1:0]     gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    always_comb begin : pick
        int j;
        gnt_valid_o = 1'b0;
        gnt_oh_o    = '0;
        gnt_idx_o   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!gnt_valid_o && req_i[j]) begin
                gnt_valid_o = 1'b1;
                gnt_oh_o[j] = 1'b1;
                gnt_idx_o   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/timer_share_scheduler.sv
// Shares one 32-bit interval timer between NUM_REQ one-shot requesters.
// Ports: req/req_delay in, grant/done/busy out, timer Avalon master
// (tmr_*), tmr_irq in, stat_done_count out.
// Macro TIMER_SHARE_SCHEDULER_STATS_EN enables the done counter.
module timer_share_scheduler
    import timer_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DELAY_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [TMR_AW-1:0]          tmr_address,
    output logic                       tmr_chipselect,
    output logic                       tmr_write_n,
    output logic [TMR_DW-1:0]          tmr_writedata,
    input  logic                       tmr_irq,
    output logic [15:0]                stat_done_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic                 abort_q, abort_d;

    logic                 arb_valid;
    logic [NUM_REQ-1:0]   arb_oh;
    logic [IDX_W-1:0]     arb_idx;
    logic [DELAY_W-1:0]   sel_delay;
    logic [NUM_REQ-1:0]   owner_oh;
    logic                 owner_req;
    logic [IDX_W-1:0]     next_ptr;

    rr_arbiter_onehot #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .gnt_valid_o (arb_valid),
        .gnt_oh_o    (arb_oh),
        .gnt_idx_o   (arb_idx)
    );

    always_comb begin
        sel_delay = '0;
        owner_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_oh[i]) sel_delay = req_delay[i*DELAY_W +: DELAY_W];
            owner_oh[i] = (idx_q == IDX_W'(i));
        end
        owner_req = |(req & owner_oh);
        next_ptr  = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        delay_d = delay_q;
        abort_d = abort_q;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    idx_d   = arb_idx;
                    delay_d = sel_delay;
                    abort_d = 1'b0;
                    state_d = ST_WR_STOP;
                end
            end
            ST_WR_STOP:  state_d = ST_WR_CLR;
            ST_WR_CLR:   state_d = ST_WR_PL;
            ST_WR_PL:    state_d = ST_WR_PH;
            ST_WR_PH:    state_d = ST_WR_START;
            ST_WR_START: state_d = ST_WAIT_IRQ;
            ST_WAIT_IRQ: begin
                // irq has priority over a same-cycle cancel
                if (tmr_irq) begin
                    state_d = ST_WR_ACK;
                end else if (!owner_req) begin
                    abort_d = 1'b1;
                    state_d = ST_WR_ABORT;
                end
            end
            ST_WR_ABORT: state_d = ST_WR_ACK;
            ST_WR_ACK: begin
                if (abort_q) begin
                    ptr_d   = next_ptr;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_d   = next_ptr;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = '0;
        tmr_writedata  = '0;
        unique case (state_q)
            ST_WR_STOP, ST_WR_ABORT: begin
                tmr_address   = TMR_ADDR_CONTROL;
                tmr_writedata = CTRL_STOP_WORD;
            end
            ST_WR_CLR, ST_WR_ACK: begin
                tmr_address   = TMR_ADDR_STATUS;
                tmr_writedata = STATUS_CLR_WORD;
            end
            ST_WR_PL: begin
                tmr_address   = TMR_ADDR_PERIOD_L;
                tmr_writedata = delay_q[TMR_DW-1:0];
            end
            ST_WR_PH: begin
                tmr_address   = TMR_ADDR_PERIOD_H;
                tmr_writedata = delay_q[DELAY_W-1:TMR_DW];
            end
            ST_WR_START: begin
                tmr_address   = TMR_ADDR_CONTROL;
                tmr_writedata = CTRL_START_WORD;
            end
            default: ;
        endcase
        unique case (state_q)
            ST_WR_STOP, ST_WR_CLR, ST_WR_PL, ST_WR_PH,
            ST_WR_START, ST_WR_ACK, ST_WR_ABORT: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != ST_IDLE);
    assign grant = busy ? owner_oh : '0;
    assign done  = (state_q == ST_DONE) ? owner_oh : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            delay_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            delay_q <= delay_d;
            abort_q <= abort_d;
        end
    end

`ifdef TIMER_SHARE_SCHEDULER_STATS_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (state_q == ST_DONE && stat_q != 16'hFFFF) begin
            stat_d = stat_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) stat_q <= '0;
        else       stat_q <= stat_d;
    end

    assign stat_done_count = stat_q;
`else
    assign stat_done_count = '0;
`endif

endmodule

// File: tb/tb_timer_share_scheduler.sv
// Self-checking bench for timer_share_scheduler with a timer model.
// Table-driven single requests plus hand-written multi-cycle sequences.
module tb_timer_share_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_delay;
    logic [3:0]   grant;
    logic [3:0]   done;
    logic         busy;
    logic [2:0]   tmr_address;
    logic         tmr_chipselect;
    logic         tmr_write_n;
    logic [15:0]  tmr_writedata;
    logic         tmr_irq;
    logic [15:0]  stat;

    logic model_irq = 1'b0;
    logic force_irq = 1'b0;
    assign tmr_irq = model_irq | force_irq;

    timer_share_scheduler #(.NUM_REQ(4), .DELAY_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_delay       (req_delay),
        .grant           (grant),
        .done            (done),
        .busy            (busy),
        .tmr_address     (tmr_address),
        .tmr_chipselect  (tmr_chipselect),
        .tmr_write_n     (tmr_write_n),
        .tmr_writedata   (tmr_writedata),
        .tmr_irq         (tmr_irq),
        .stat_done_count (stat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // timer model: irq rises D+3 cycles after the START write
    logic [2:0]  wa [$];
    logic [15:0] wd [$];
    logic [15:0] per_l = 16'h0;
    logic [15:0] per_h = 16'h0;
    logic        armed = 1'b0;
    longint      deadline = 0;
    int          done_cnt [4] = '{0, 0, 0, 0};
    int          multi_grant = 0;

    always @(negedge clk) begin
        if (tmr_chipselect && !tmr_write_n) begin
            wa.push_back(tmr_address);
            wd.push_back(tmr_writedata);
            case (tmr_address)
                3'd0: model_irq = 1'b0;
                3'd1: begin
                    if (tmr_writedata[3]) armed = 1'b0;
                    if (tmr_writedata[2]) begin
                        armed = 1'b1;
                        deadline = longint'(cyc) + longint'({per_h, per_l}) + 3;
                    end
                end
                3'd2: per_l = tmr_writedata;
                3'd3: per_h = tmr_writedata;
                default: ;
            endcase
        end
        if (armed && longint'(cyc) == deadline) begin
            model_irq = 1'b1;
            armed = 1'b0;
        end
        if ((grant & (grant - 4'd1)) != 4'd0) multi_grant++;
        for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
    end

    int passed = 0;
    int total = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        total++;
        $display("FAIL %s: timed out, required event never seen", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int gc, output bit ok);
        ok = 1'b0;
        gc = 0;
        for (int n = 0; n < 20 && !ok; n++) begin
            tick();
            if (grant != 4'd0) begin
                ok = 1'b1;
                gc = cyc;
            end
        end
        if (!ok) timeout("wait_grant");
    endtask

    task automatic wait_done(input int idx, input int budget,
                             output int dc, output bit ok);
        ok = 1'b0;
        dc = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            if (done[idx]) begin
                ok = 1'b1;
                dc = cyc;
            end
        end
        if (!ok) timeout("wait_done");
    endtask

    task automatic exp_wr(input int base, input int k,
                          input logic [2:0] a, input logic [15:0] d);
        if (base + k < wa.size()) begin
            check($sformatf("wr%0d_addr", k), 32'(wa[base+k]), 32'(a));
            check($sformatf("wr%0d_data", k), 32'(wd[base+k]), 32'(d));
        end else begin
            timeout($sformatf("wr%0d_missing", k));
        end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] delay;
        logic [3:0]  exp_grant;
        int          exp_lat;
    } vec_t;

    vec_t vecs [4];

    initial begin : main
        int  g, dc, base, d0;
        bit  ok;
        int  ord [5];
        int  mlat [5];
        int  mdone [4];
        int  dsnap [4];
        int  exp_stat;

        vecs[0] = '{0, 32'd100, 4'b0001, 109};
        vecs[1] = '{2, 32'd250, 4'b0100, 259};
        vecs[2] = '{1, 32'd0,   4'b0010, 9};
        vecs[3] = '{3, 32'd5,   4'b1000, 14};
        ord   = '{0, 1, 2, 3, 0};
        mlat  = '{19, 29, 39, 49, 19};
        mdone = '{2, 1, 1, 1};

        reset = 1'b1;
        req = 4'd0;
        req_delay = '0;
        repeat (3) tick();
        check("rst_grant", 32'(grant), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_write_n", 32'(tmr_write_n), 1);
        check("rst_cs", 32'(tmr_chipselect), 0);
        check("rst_stat", 32'(stat), 0);
        reset = 1'b0;
        tick();

        foreach (vecs[v]) begin
            base = wa.size();
            d0 = done_cnt[vecs[v].idx];
            req_delay[vecs[v].idx*32 +: 32] = vecs[v].delay;
            req[vecs[v].idx] = 1'b1;
            wait_grant(g, ok);
            if (ok) begin
                check("vec_grant", 32'(grant), 32'(vecs[v].exp_grant));
                wait_done(vecs[v].idx, int'(vecs[v].delay) + 40, dc, ok);
                if (ok) check("vec_latency", 32'(dc - g), 32'(vecs[v].exp_lat));
            end
            req[vecs[v].idx] = 1'b0;
            tick();
            tick();
            check("vec_idle", 32'(busy), 0);
            check("vec_done_cnt", 32'(done_cnt[vecs[v].idx] - d0), 1);
            check("vec_wr_cnt", 32'(wa.size() - base), 6);
            exp_wr(base, 0, 3'd1, 16'h0008);
            exp_wr(base, 1, 3'd0, 16'h0000);
            exp_wr(base, 2, 3'd2, vecs[v].delay[15:0]);
            exp_wr(base, 3, 3'd3, vecs[v].delay[31:16]);
            exp_wr(base, 4, 3'd1, 16'h0005);
            exp_wr(base, 5, 3'd0, 16'h0000);
        end

        // all four held: round robin 0,1,2,3 then back to 0
        dsnap = done_cnt;
        req_delay = {32'd40, 32'd30, 32'd20, 32'd10};
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g, ok);
            if (!ok) break;
            check($sformatf("rr_grant%0d", k), 32'(grant), 32'(1 << ord[k]));
            wait_done(ord[k], 100, dc, ok);
            if (!ok) break;
            check($sformatf("rr_lat%0d", k), 32'(dc - g), 32'(mlat[k]));
        end
        req = 4'd0;
        tick();
        tick();
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_done_cnt%0d", i),
                  32'(done_cnt[i] - dsnap[i]), 32'(mdone[i]));

        // cancel 5 cycles into WAIT_IRQ
        base = wa.size();
        d0 = done_cnt[1];
        req_delay[63:32] = 32'd1000;
        req[1] = 1'b1;
        wait_grant(g, ok);
        check("cancel_grant", 32'(grant), 32'h2);
        repeat (10) tick();
        check("cancel_busy_wait", 32'(busy), 1);
        req[1] = 1'b0;
        tick();
        tick();
        check("cancel_busy_ack", 32'(busy), 1);
        tick();
        check("cancel_busy_low", 32'(busy), 0);
        check("cancel_no_done", 32'(done_cnt[1] - d0), 0);
        check("cancel_wr_cnt", 32'(wa.size() - base), 7);
        exp_wr(base, 2, 3'd2, 16'h03E8);
        exp_wr(base, 4, 3'd1, 16'h0005);
        exp_wr(base, 5, 3'd1, 16'h0008);
        exp_wr(base, 6, 3'd0, 16'h0000);

        // drop coincident with irq: irq wins
        base = wa.size();
        req_delay[63:32] = 32'h0003_0007;
        req[1] = 1'b1;
        wait_grant(g, ok);
        check("coin_grant", 32'(grant), 32'h2);
        repeat (6) tick();
        req[1] = 1'b0;
        force_irq = 1'b1;
        tick();
        check("coin_ack_addr", 32'(tmr_address), 0);
        check("coin_ack_cs", 32'(tmr_chipselect), 1);
        force_irq = 1'b0;
        tick();
        check("coin_done", 32'(done), 32'h2);
        tick();
        check("coin_idle", 32'(busy), 0);
        check("coin_wr_cnt", 32'(wa.size() - base), 6);
        exp_wr(base, 2, 3'd2, 16'h0007);
        exp_wr(base, 3, 3'd3, 16'h0003);
        exp_wr(base, 5, 3'd0, 16'h0000);

`ifdef TIMER_SHARE_SCHEDULER_STATS_EN
        exp_stat = 10;
`else
        exp_stat = 0;
`endif
        check("stat_count", 32'(stat), 32'(exp_stat));

        // reset while writing period_h
        base = wa.size();
        req_delay[31:0] = 32'd50;
        req[0] = 1'b1;
        wait_grant(g, ok);
        check("rstmid_grant", 32'(grant), 32'h1);
        repeat (3) tick();
        check("rstmid_in_ph", 32'(tmr_address), 3);
        reset = 1'b1;
        tick();
        check("rstmid_grant0", 32'(grant), 0);
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_write_n", 32'(tmr_write_n), 1);
        check("rstmid_cs", 32'(tmr_chipselect), 0);
        check("rstmid_stat", 32'(stat), 0);
        reset = 1'b0;
        req = 4'd0;
        tick();
        tick();
        check("rstmid_idle", 32'(busy), 0);
        check("rstmid_wr_cnt", 32'(wa.size() - base), 4);
        check("one_grant_max", 32'(multi_grant), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/timer_share_scheduler.md
Name: timer_share_scheduler

Overview:
- Shares the single 32-bit interval timer core between NUM_REQ hardware requesters, each needing a one-shot delay.
- Arbitrates round-robin and programs the timer over its 16-bit Avalon-MM slave port (master side).
- Waits for the timer irq, clears the status, and returns a one-cycle done pulse to the winning requester.
- Sits between requester logic (video DMA pacing, frame timing) and the timer slave, replacing CPU-driven timer sequencing.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DELAY_W, 32, delay width; fixed by the timer's period_h:period_l pair.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester; must hold until done or be dropped to cancel.
- req_delay  in  NUM_REQ*DELAY_W  per-requester period; slice i is bits [i*32+31:i*32].
- grant  out  NUM_REQ  one-hot owner of the timer; zero when idle.
- done  out  NUM_REQ  one-hot, one-cycle pulse on expiry.
- busy  out  1  high whenever state is not IDLE.
- tmr_address  out  3  timer slave word address.
- tmr_chipselect  out  1  timer slave select.
- tmr_write_n  out  1  active-low write strobe.
- tmr_writedata  out  16  timer write data.
- tmr_irq  in  1  timer interrupt.
- stat_done_count  out  16  completed-expiry count (see Optional Feature).

Behaviour:
- Timer map (fixed):
  - addr0 status: any write clears timeout.
  - addr1 control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - addr2 period_l.
  - addr3 period_h.
  - Writes complete in one cycle; no waitrequest.
- Reset values: all outputs 0 except tmr_write_n=1; state IDLE; round-robin pointer=0. Reset mid-operation abandons the sequence immediately and does not touch the timer.
- FSM, one cycle per write state:
  - IDLE: if any req, pick the first set bit at or above the pointer (wrapping), latch its index and delay, assert grant next cycle, go to WR_STOP.
  - WR_STOP: addr1 <= 0x0008.
  - WR_CLR: addr0 <= 0x0000.
  - WR_PL: addr2 <= delay[15:0].
  - WR_PH: addr3 <= delay[31:16].
  - WR_START: addr1 <= 0x0005 (START|ITO, one-shot, CONT=0).
  - WAIT_IRQ: bus idle; on tmr_irq go to WR_ACK.
  - WR_ACK: addr0 <= 0x0000.
  - DONE: done[idx] pulses, grant drops, pointer <= idx+1 mod NUM_REQ, go to IDLE.
- Bus signalling: tmr_chipselect=1 and tmr_write_n=0 only in write states; otherwise chipselect=0, write_n=1, address and writedata 0.
- Latency: with delay D, done pulses exactly D+9 cycles after the first cycle grant is high. D=0 is legal and gives done at +9.
- Cancel: if req[idx] drops in WAIT_IRQ and tmr_irq is low, go to WR_ABORT (addr1 <= 0x0008), then WR_ACK, then IDLE. No done pulse; pointer still advances. If the drop and tmr_irq coincide, irq wins and done pulses.
- req changes outside IDLE/WAIT_IRQ are ignored. req_delay is sampled only at grant.
- A requester that holds req after done may be regranted only after every other pending requester is served.

Optional Feature:
- Macro: TIMER_SHARE_SCHEDULER_STATS_EN.
- Defined: stat_done_count increments on every done pulse and saturates at 0xFFFF. It is cleared by reset only. Cancels are not counted.
- Undefined: stat_done_count tied to 0 and no counter logic.

Decomposition:
- Shared package timer_share_pkg holds:
  - FSM state enum.
  - Timer address constants: TMR_ADDR_STATUS=0, TMR_ADDR_CONTROL=1, TMR_ADDR_PERIOD_L=2, TMR_ADDR_PERIOD_H=3.
  - Control bit constants and CTRL_STOP_WORD=0x0008, CTRL_START_WORD=0x0005.
- One natural sub-module: rr_arbiter_onehot (NUM_REQ-wide round-robin pick with pointer input, one-hot and index outputs).

Test Plan:
- Single requester, req[0]=1, delay 100, with the timer core attached: bus sequence (1,0x0008)(0,0)(2,100)(3,0)(1,0x0005), then (0,0) after irq. done[0] pulses at grant+109.
- All four requesters asserted together with delays 10/20/30/40: grants occur in order 0,1,2,3, one done each, never two grants at once.
- After req[2] is served and all four are still high: next grant is 3, then 0.
- Cancel: req[1] drops 5 cycles into WAIT_IRQ with delay 1000: writes (1,0x0008),(0,0), no done, busy low 3 cycles later.
- Cancel coincident with tmr_irq: done[1] pulses and no abort write is issued.
- Reset asserted during WR_PH: next cycle grant=0, busy=0, write_n=1. Stats build: 3 completions plus 1 cancel give stat_done_count=3.
